// File: rtl/param_datapath.sv
// Single-bus register datapath: a six-state sequencer moves operands through
// Y and a double-width Z register pair, writing back to the register file or HI/LO.
module param_datapath #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter bit ZERO_R0  = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic [AW-1:0]     rc,
  input  logic              ext_we,
  input  logic [AW-1:0]     ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic [AW-1:0]     dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] bus_data,
  output logic [DATA_W-1:0] hi_data,
  output logic [DATA_W-1:0] lo_data,
  output logic              zero_flag
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_MUL = 3'b101, OP_MOV = 3'b110, OP_NOT = 3'b111
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [AW-1:0]       ra_q, rb_q, rc_q;
  logic [DATA_W-1:0]   y_q, zhi_q, zlo_q, hi_q, lo_q;
  logic                zero_q;
  logic [DATA_W-1:0]   regs_q  [NUM_REGS];
  logic [DATA_W-1:0]   regs_rd [NUM_REGS];

  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   alu_hi, alu_lo;
  logic [2*DATA_W-1:0] product;
  logic                rf_we;
  logic [AW-1:0]       rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  // Read view of the register file with R0 forced to zero when configured.
  always_comb begin
    regs_rd = regs_q;
    if (ZERO_R0) regs_rd[0] = '0;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    bus     = '0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T1;
      S_T1: begin
        bus     = regs_rd[rb_q];
        state_d = S_T2;
      end
      S_T2: begin
        bus     = regs_rd[rc_q];
        state_d = S_T3;
      end
      S_T3: begin
        bus     = zlo_q;
        state_d = (op_q == OP_MUL) ? S_T4 : S_DONE;
      end
      S_T4: begin
        bus     = zhi_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Both operands sign-extended to full width, so the low 2*DATA_W bits are the signed product.
  assign product = {{DATA_W{y_q[DATA_W-1]}}, y_q} * {{DATA_W{bus[DATA_W-1]}}, bus};

  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    unique case (op_q)
      OP_ADD:  alu_lo = y_q + bus;
      OP_SUB:  alu_lo = y_q - bus;
      OP_AND:  alu_lo = y_q & bus;
      OP_OR:   alu_lo = y_q | bus;
      OP_XOR:  alu_lo = y_q ^ bus;
      OP_MUL:  {alu_hi, alu_lo} = product;
      OP_MOV:  alu_lo = y_q;
      OP_NOT:  alu_lo = ~y_q;
      default: alu_lo = '0;
    endcase
  end

  // External loads only in IDLE; writeback only in T3 of a non-MUL operation.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ext_waddr;
    rf_wdata = ext_wdata;
    if (state_q == S_IDLE && ext_we) begin
      rf_we = 1'b1;
    end else if (state_q == S_T3 && op_q != OP_MUL) begin
      rf_we    = 1'b1;
      rf_waddr = ra_q;
      rf_wdata = bus;
    end
    if (ZERO_R0 && rf_waddr == '0) rf_we = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      y_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        op_q <= op_e'(opcode);
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
      unique case (state_q)
        S_T1: y_q <= bus;
        S_T2: begin
          zhi_q <= alu_hi;
          zlo_q <= alu_lo;
        end
        S_T3: begin
          if (op_q == OP_MUL) lo_q   <= bus;
          else                zero_q <= (zlo_q == '0);
        end
        S_T4: begin
          hi_q   <= bus;
          zero_q <= ({zhi_q, zlo_q} == '0);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the register file is built from flops and must clear on clr, so it is reset like any other state; a RAM-mapped array would not be.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  assign dbg_rdata = regs_rd[dbg_raddr];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign bus_data  = bus;
  assign hi_data   = hi_q;
  assign lo_data   = lo_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_param_datapath.sv
// Directed self-checking bench for param_datapath at its default parameters;
// inputs change and outputs are sampled on the falling clock edge.
module tb_param_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        ext_we;
  logic [3:0]  ext_waddr;
  logic [31:0] ext_wdata;
  logic [3:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        busy, done;
  logic [31:0] bus_data, hi_data, lo_data;
  logic        zero_flag;

  int checks = 0;
  int errors = 0;
  int dones;

  param_datapath dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .opcode    (opcode),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .ext_we    (ext_we),
    .ext_waddr (ext_waddr),
    .ext_wdata (ext_wdata),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .busy      (busy),
    .done      (done),
    .bus_data  (bus_data),
    .hi_data   (hi_data),
    .lo_data   (lo_data),
    .zero_flag (zero_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    dbg_raddr = a;
    #1;
    check(tag, {32'h0, dbg_rdata}, {32'h0, exp});
  endtask

  task automatic ext_write(input logic [3:0] a, input logic [31:0] d);
    ext_we    = 1'b1;
    ext_waddr = a;
    ext_wdata = d;
    @(negedge clk);
    ext_we    = 1'b0;
  endtask

  // Launches one operation, scrambles the inputs after the start edge and
  // measures the falling edges from the start edge until done is seen.
  task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input int exp_lat, input string tag);
    int lat;
    start  = 1'b1;
    opcode = op;
    ra     = a;
    rb     = b;
    rc     = c;
    @(negedge clk);
    start  = 1'b0;
    ext_we = 1'b0;
    opcode = ~op;
    ra     = ~a;
    rb     = ~b;
    rc     = ~c;
    lat    = 1;
    while (done !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    check({tag, "_idle"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
    ext_we = 1'b0; ext_waddr = '0; ext_wdata = '0; dbg_raddr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_bus",  {32'h0, bus_data}, 64'h0);
    check("rst_zero", {63'h0, zero_flag}, 64'h0);
    check("rst_hi",   {32'h0, hi_data}, 64'h0);
    check("rst_lo",   {32'h0, lo_data}, 64'h0);
    check_reg("rst_r5", 4'd5, 32'h0);
    @(negedge clk);
    clr = 1'b0;

    // ADD with cycle-by-cycle bus/busy/done timing
    ext_write(4'd2, 32'd5);
    ext_write(4'd3, 32'd7);
    check_reg("ext_r2", 4'd2, 32'd5);
    @(negedge clk);
    start = 1'b1; opcode = 3'b000; ra = 4'd1; rb = 4'd2; rc = 4'd3; dbg_raddr = 4'd1;
    @(negedge clk);
    start = 1'b0;
    check("add_t1_busy", {63'h0, busy}, 64'h1);
    check("add_t1_bus",  {32'h0, bus_data}, 64'd5);
    check("add_t1_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    check("add_t2_bus",  {32'h0, bus_data}, 64'd7);
    @(negedge clk);
    check("add_t3_bus",  {32'h0, bus_data}, 64'd12);
    check("add_t3_r1",   {32'h0, dbg_rdata}, 64'h0);
    check("add_t3_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    check("add_dn_done", {63'h0, done}, 64'h1);
    check("add_dn_busy", {63'h0, busy}, 64'h1);
    check("add_dn_r1",   {32'h0, dbg_rdata}, 64'd12);
    check("add_dn_bus",  {32'h0, bus_data}, 64'h0);
    check("add_dn_zero", {63'h0, zero_flag}, 64'h0);
    @(negedge clk);
    check("add_end_busy", {63'h0, busy}, 64'h0);
    check("add_end_done", {63'h0, done}, 64'h0);

    // SUB wrap-around and zero result
    run_op(3'b001, 4'd6, 4'd2, 4'd3, 4, "sub_wrap");
    check_reg("sub_r6", 4'd6, 32'hFFFF_FFFE);
    check("sub_wrap_zero", {63'h0, zero_flag}, 64'h0);
    run_op(3'b001, 4'd7, 4'd2, 4'd2, 4, "sub_self");
    check_reg("sub_r7", 4'd7, 32'h0);
    check("sub_self_zero", {63'h0, zero_flag}, 64'h1);

    // Signed MUL: -1 * 7
    ext_write(4'd4, 32'hFFFF_FFFF);
    ext_write(4'd5, 32'd7);
    run_op(3'b101, 4'd8, 4'd4, 4'd5, 5, "mul");
    check("mul_lo",   {32'h0, lo_data}, 64'hFFFF_FFF9);
    check("mul_hi",   {32'h0, hi_data}, 64'hFFFF_FFFF);
    check("mul_zero", {63'h0, zero_flag}, 64'h0);
    check_reg("mul_r8", 4'd8, 32'h0);

    // Logic ops and MOV on R2=5, R3=7
    run_op(3'b100, 4'd12, 4'd2, 4'd3, 4, "xor");
    check_reg("xor_r12", 4'd12, 32'd2);
    run_op(3'b011, 4'd13, 4'd2, 4'd3, 4, "or");
    check_reg("or_r13", 4'd13, 32'd7);
    run_op(3'b010, 4'd13, 4'd2, 4'd3, 4, "and");
    check_reg("and_r13", 4'd13, 32'd5);
    run_op(3'b110, 4'd14, 4'd3, 4'd2, 4, "mov");
    check_reg("mov_r14", 4'd14, 32'd7);

    // R0 hard-wired to zero
    ext_write(4'd0, 32'h1234);
    check_reg("r0_ext", 4'd0, 32'h0);
    run_op(3'b000, 4'd0, 4'd2, 4'd3, 4, "add_r0");
    check_reg("r0_wb", 4'd0, 32'h0);
    run_op(3'b111, 4'd9, 4'd0, 4'd0, 4, "not_r0");
    check_reg("not_r9", 4'd9, 32'hFFFF_FFFF);

    // ext write and start in the same IDLE cycle; then ra == rb == rc
    ext_we = 1'b1; ext_waddr = 4'd10; ext_wdata = 32'd100;
    run_op(3'b000, 4'd11, 4'd10, 4'd3, 4, "same_cyc");
    check_reg("same_cyc_r11", 4'd11, 32'd107);
    run_op(3'b000, 4'd10, 4'd10, 4'd10, 4, "alias");
    check_reg("alias_r10", 4'd10, 32'd200);

    // start and ext_we during T2 are ignored
    start = 1'b1; opcode = 3'b001; ra = 4'd15; rb = 4'd3; rc = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = 3'b000; ra = 4'd14;
    ext_we = 1'b1; ext_waddr = 4'd14; ext_wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; ext_we = 1'b0;
    dones = 0;
    repeat (8) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    check("busy_ign_dones", 64'(dones), 64'd1);
    check_reg("busy_ign_r15", 4'd15, 32'd2);
    check_reg("busy_ign_r14", 4'd14, 32'd7);

    // clr during T2 of an operation
    run_op(3'b001, 4'd7, 4'd2, 4'd2, 4, "pre_clr");
    check("pre_clr_zero", {63'h0, zero_flag}, 64'h1);
    start = 1'b1; opcode = 3'b000; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_busy", {63'h0, busy}, 64'h0);
    check("clr_done", {63'h0, done}, 64'h0);
    check("clr_bus",  {32'h0, bus_data}, 64'h0);
    check("clr_zero", {63'h0, zero_flag}, 64'h0);
    check("clr_hi",   {32'h0, hi_data}, 64'h0);
    check("clr_lo",   {32'h0, lo_data}, 64'h0);
    check_reg("clr_r1", 4'd1, 32'h0);
    check_reg("clr_r2", 4'd2, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("post_clr_busy", {63'h0, busy}, 64'h0);
    check_reg("post_clr_r1", 4'd1, 32'h0);

    // Normal operation after reset
    ext_write(4'd2, 32'd3);
    ext_write(4'd3, 32'd4);
    run_op(3'b000, 4'd1, 4'd2, 4'd3, 4, "post_clr_add");
    check_reg("post_clr_add_r1", 4'd1, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 Parameter DATA_W, default 32, width of registers, bus, Y, Z_HI, Z_LO, HI and LO.
REQ-002 Parameter NUM_REGS, default 16, general register count, power of two >= 2; AW = log2(NUM_REGS).
REQ-003 Parameter ZERO_R0, default 1; when 1, R0 reads as zero and discards writes.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 clr  in  1  asynchronous active-high reset.
REQ-007 start  in  1  requests an operation; sampled only in IDLE.
REQ-008 opcode  in  3  operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 MOV, 111 NOT.
REQ-009 ra, rb, rc  in  AW each  destination, first source and second source register indices.
REQ-010 ext_we, ext_waddr[AW], ext_wdata[DATA_W]  in  external register load port.
REQ-011 dbg_raddr  in  AW, and dbg_rdata  out  DATA_W  combinational register read.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 bus_data  out  DATA_W  current shared-bus value.
REQ-015 hi_data, lo_data  out  DATA_W each  HI and LO register contents.
REQ-016 zero_flag  out  1  result-zero status of the last completed operation.

Function
REQ-017 States: IDLE, T1, T2, T3, T4, DONE; IDLE->T1 on start; T1->T2->T3; T3->T4 for MUL, T3->DONE otherwise; T4->DONE; DONE->IDLE.
REQ-018 opcode, ra, rb and rc are latched on the IDLE->T1 edge; input changes afterwards have no effect on the operation.
REQ-019 T1: bus = R[rb]; Y loads bus at end of cycle.
REQ-020 T2: bus = R[rc]; {Z_HI,Z_LO} loads ALU(Y, bus) at end of cycle.
REQ-021 ALU, with Z_HI = 0 except for MUL: ADD Y+bus mod 2^DATA_W; SUB Y-bus mod 2^DATA_W; AND, OR, XOR bitwise; MUL signed two's-complement 2*DATA_W-bit product; MOV Y; NOT ~Y.
REQ-022 T3, non-MUL: bus = Z_LO; R[ra] loads bus.
REQ-023 T3, MUL: bus = Z_LO; LO loads bus; R[ra] is unchanged.
REQ-024 T4 (MUL only): bus = Z_HI; HI loads bus.
REQ-025 In IDLE and DONE, bus = 0.
REQ-026 zero_flag updates at the final write edge: non-MUL, Z_LO == 0; MUL, full product == 0. It holds otherwise.
REQ-027 Latency: with start sampled at edge n, the non-MUL writeback occurs at edge n+3, done is high for the cycle after n+3, and busy falls after edge n+4; each MUL step is one edge later.
REQ-028 start while busy is ignored and is not queued.
REQ-029 ext_we writes ext_wdata to R[ext_waddr] only in IDLE; it is ignored while busy.
REQ-030 start and ext_we in the same IDLE cycle: the ext write commits and the operation starts; T1 reads the new value.
REQ-031 ra == rb == rc is legal; sources are read before writeback.
REQ-032 ZERO_R0=1: R0 reads 0 on the bus and on dbg_rdata, and writes to R0 from ext or writeback are discarded; ZERO_R0=0: R0 is an ordinary register.
REQ-033 dbg_rdata = R[dbg_raddr], combinational, and reflects a write on the cycle after it.

Reset
REQ-034 clr asserted, at any time including mid-operation: state IDLE, all registers, Y, Z_HI, Z_LO, HI, LO and latched fields are 0; busy, done and zero_flag are 0; bus_data is 0; no writeback occurs.
REQ-035 Operation resumes on the first rising edge after clr deasserts; start is sampled on that edge.

Verification (DATA_W=32, NUM_REGS=16, ZERO_R0=1)
REQ-036 ext load R2=5, R3=7; ADD ra=1 rb=2 rc=3 -> R1=12 at edge n+3; done high one cycle; busy for 4 cycles; zero_flag=0.
REQ-037 SUB R2-R3 -> Ra=0xFFFFFFFE, zero_flag=0; then SUB R2-R2 -> Ra=0, zero_flag=1.
REQ-038 R4=0xFFFFFFFF, R5=7; MUL rb=4 rc=5 -> LO=0xFFFFFFF9, HI=0xFFFFFFFF, R[ra] unchanged, done after edge n+4.
REQ-039 ext write R0=0x1234 -> dbg_rdata(R0)=0; ADD ra=0 -> R0 still reads 0; NOT rb=0 -> Ra=0xFFFFFFFF.
REQ-040 start pulsed and ext_we asserted during T2 -> both ignored, one done only, target register unchanged; clr pulsed in T2 of another op -> all outputs 0, no writeback, IDLE next cycle.
